pwm_multi_ch: RTL and testbench

- Parametrised successor to the fixed buzzer/RGB PWM block: N-channel PWM generator sharing one period counter, with per-channel duty, enable and polarity.
- Configured through a simple register write/read port driven from the FlexBus slave decode.
- Period and duty values are double-buffered (shadow → active) and swapped only at the period boundary, so outputs never glitch mid-period.
- Sits between the FlexBus register decode and the board buzzer/LED/IO pins.

---
 rtl/pwm_multi_ch.sv | 141 ++++++++++++++
 tb/tb_pwm_multi_ch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N-channel PWM generator built around one shared period counter.
// Period and duty are double-buffered. Software writes the shadow copies, and
// the active copies reload only while idle or at the end of a period, so a
// running output never changes shape mid-period.
//
// Read port: RD_EN is a single-cycle request that is always accepted, with no
// back-pressure. RD_VALID pulses exactly one cycle later with RD_DATA, and
// RD_DATA then holds its value until the next request.
module pwm_multi_ch #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [31:0]       WR_DATA,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [31:0]       RD_DATA,
  output logic              RD_VALID,
  output logic [CH_NUM-1:0] PWM_OUT,
  output logic              PRD_TICK
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_CNT    = ADDR_W'(2);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  logic              en;
  logic [CH_NUM-1:0] ch_en;
  logic [CH_NUM-1:0] pol;
  logic [CNT_W-1:0]  period_sh;
  logic [CNT_W-1:0]  period_act;
  logic [CNT_W-1:0]  duty_sh  [CH_NUM];
  logic [CNT_W-1:0]  duty_act [CH_NUM];
  logic [CNT_W-1:0]  cnt;

  logic              period_zero;
  logic              terminal;
  logic              load;
  logic [CH_NUM-1:0] pwm_next;
  logic [2*CH_NUM:0] ctrl_word;
  logic [31:0]       rd_mux;

  // Period status: terminal count, and when the shadows may move to active.
  always_comb begin
    period_zero = (period_act == '0);
    terminal    = !period_zero && (cnt >= period_act - CNT_ONE);
    load        = !en || period_zero || terminal;
  end

  // Register writes: CTRL is live at once, while PERIOD/DUTY land in shadows.
  always_ff @(posedge CLK) begin
    if (RST) begin
      en        <= 1'b0;
      ch_en     <= '0;
      pol       <= '0;
      period_sh <= '0;
      for (int i = 0; i < CH_NUM; i++) duty_sh[i] <= '0;
    end else if (WR_EN) begin
      if (WR_ADDR == ADDR_CTRL) begin
        en    <= WR_DATA[0];
        ch_en <= WR_DATA[CH_NUM:1];
        pol   <= WR_DATA[2*CH_NUM:CH_NUM+1];
      end
      if (WR_ADDR == ADDR_PERIOD) period_sh <= WR_DATA[CNT_W-1:0];
      for (int i = 0; i < CH_NUM; i++) begin
        if (WR_ADDR == ADDR_W'(3 + i)) duty_sh[i] <= WR_DATA[CNT_W-1:0];
      end
    end
  end

  // Active copies follow the shadows only at safe points. A write on the same
  // edge is seen one period later, because the old shadow value is sampled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      period_act <= '0;
      for (int i = 0; i < CH_NUM; i++) duty_act[i] <= '0;
    end else if (load) begin
      period_act <= period_sh;
      for (int i = 0; i < CH_NUM; i++) duty_act[i] <= duty_sh[i];
    end
  end

  // Shared counter: wraps at the active period and idles at zero when off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (!en || period_zero || terminal) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Per-channel compare. A zero period forces every channel to its idle level.
  always_comb begin
    pwm_next = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      pwm_next[i] = pol[i] ^ (en & ch_en[i] & !period_zero & (cnt < duty_act[i]));
    end
  end

  // Registered outputs: PWM levels and the end-of-period tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PWM_OUT  <= '0;
      PRD_TICK <= 1'b0;
    end else begin
      PWM_OUT  <= pwm_next;
      PRD_TICK <= en && terminal;
    end
  end

  // Read mux: shadows are reported (not active copies). Unmapped reads return 0.
  always_comb begin
    ctrl_word = {pol, ch_en, en};
    rd_mux    = '0;
    if (RD_ADDR == ADDR_CTRL) rd_mux = 32'(ctrl_word);
    if (RD_ADDR == ADDR_PERIOD) rd_mux = 32'(period_sh);
    if (RD_ADDR == ADDR_CNT) rd_mux = 32'(cnt);
    for (int i = 0; i < CH_NUM; i++) begin
      if (RD_ADDR == ADDR_W'(3 + i)) rd_mux = 32'(duty_sh[i]);
    end
  end

  // Read response register: one-cycle latency, and the data holds between reads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD_DATA  <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= RD_EN;
      if (RD_EN) RD_DATA <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: default parameters (4 channels, 32-bit counter).
module tb_pwm_multi_ch;

  localparam int CH_NUM = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic [CH_NUM-1:0] pwm_out;
  logic              prd_tick;

  int tests_run    = 0;
  int tests_failed = 0;

  pwm_multi_ch #(.CH_NUM(CH_NUM), .CNT_W(32), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .RD_VALID(rd_valid),
    .PWM_OUT(pwm_out), .PRD_TICK(prd_tick)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                          output logic valid);
    rd_en = 1'b1; rd_addr = addr;
    tick();
    rd_en = 1'b0;
    data  = rd_data;
    valid = rd_valid;
  endtask

  // Poll CNT until it reads target. After the return, the live count is target+1.
  task automatic wait_cnt(input logic [31:0] target, output bit ok);
    logic [31:0] d;
    logic        v;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      read_reg(8'd2, d, v);
      if (d == target) ok = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    rst = 1'b1;
    ticks(3);
    tests_run++;
    if (pwm_out !== 4'b0000) begin tests_failed++; $display("FAIL reset_pwm: got %b want 0000", pwm_out); end
    tests_run++;
    if (prd_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %b want 0", prd_tick); end
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_rd: got valid=%b data=%h want 0/0", rd_valid, rd_data);
    end
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      read_reg(ADDR_W'(a), d, v);
      tests_run++;
      if (d !== 32'h0 || v !== 1'b1) begin
        tests_failed++; $display("FAIL reset_reg%0d: got data=%h valid=%b want 0/1", a, d, v);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_pwm;
    logic       exp_tick;
    write_reg(8'd1, 32'd10);
    write_reg(8'd3, 32'd3);
    write_reg(8'd0, 32'h3);
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_pwm  = (((k - 1) % 10) < 3) ? 4'b0001 : 4'b0000;
      exp_tick = (((k - 1) % 10) == 9);
      tests_run++;
      if (pwm_out !== exp_pwm) begin tests_failed++; $display("FAIL basic_pwm k=%0d: got %b want %b", k, pwm_out, exp_pwm); end
      tests_run++;
      if (prd_tick !== exp_tick) begin tests_failed++; $display("FAIL basic_tick k=%0d: got %b want %b", k, prd_tick, exp_tick); end
    end
  endtask

  task automatic test_duty_update();
    bit         ok;
    int         c;
    int         duty;
    logic [3:0] exp_pwm;
    wait_cnt(32'd3, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL dupd_sync: got timeout want cnt=3"); end
    write_reg(8'd3, 32'd7);
    tests_run++;
    if (pwm_out !== 4'b0000) begin tests_failed++; $display("FAIL dupd_cnt4: got %b want 0000", pwm_out); end
    for (int j = 0; j < 15; j++) begin
      tick();
      c       = (5 + j) % 10;
      duty    = (j < 5) ? 3 : 7;
      exp_pwm = (c < duty) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (pwm_out !== exp_pwm) begin tests_failed++; $display("FAIL dupd_pwm j=%0d: got %b want %b", j, pwm_out, exp_pwm); end
    end
  endtask

  task automatic test_duty_terminal();
    bit         ok;
    int         duty;
    logic [3:0] exp_pwm;
    write_reg(8'd3, 32'd3);
    wait_cnt(32'd8, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL dterm_sync: got timeout want cnt=8"); end
    write_reg(8'd3, 32'd7);
    for (int j = 0; j < 20; j++) begin
      tick();
      duty    = (j < 10) ? 3 : 7;
      exp_pwm = ((j % 10) < duty) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (pwm_out !== exp_pwm) begin tests_failed++; $display("FAIL dterm_pwm j=%0d: got %b want %b", j, pwm_out, exp_pwm); end
    end
  endtask

  task automatic test_duty_bounds();
    logic [31:0] ctrl_v [4];
    logic [31:0] duty_v [4];
    logic [3:0]  exp_v  [4];
    int          nticks;
    ctrl_v = '{32'h3, 32'h3, 32'h3, 32'h23};
    duty_v = '{32'd0, 32'd8, 32'd200, 32'd0};
    exp_v  = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};
    write_reg(8'd1, 32'd8);
    for (int t = 0; t < 4; t++) begin
      write_reg(8'd0, ctrl_v[t]);
      write_reg(8'd3, duty_v[t]);
      ticks(25);
      nticks = 0;
      for (int j = 0; j < 16; j++) begin
        tick();
        if (prd_tick === 1'b1) nticks++;
        tests_run++;
        if (pwm_out !== exp_v[t]) begin
          tests_failed++; $display("FAIL bounds_pwm duty=%0d j=%0d: got %b want %b", duty_v[t], j, pwm_out, exp_v[t]);
        end
      end
      tests_run++;
      if (nticks != 2) begin tests_failed++; $display("FAIL bounds_ticks duty=%0d: got %0d want 2", duty_v[t], nticks); end
    end
  endtask

  task automatic test_period_zero();
    logic [31:0] d;
    logic        v;
    logic [3:0]  exp_pwm;
    logic        exp_tick;
    write_reg(8'd3, 32'd2);
    write_reg(8'd1, 32'd0);
    ticks(20);
    for (int j = 0; j < 10; j++) begin
      tick();
      tests_run++;
      if (pwm_out !== 4'b0001 || prd_tick !== 1'b0) begin
        tests_failed++; $display("FAIL pzero_idle j=%0d: got pwm=%b tick=%b want 0001/0", j, pwm_out, prd_tick);
      end
    end
    read_reg(8'd2, d, v);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL pzero_cnt: got %0d want 0", d); end
    write_reg(8'd1, 32'd4);
    tick();
    for (int j = 0; j < 12; j++) begin
      tick();
      exp_pwm  = ((j % 4) < 2) ? 4'b0000 : 4'b0001;
      exp_tick = ((j % 4) == 3);
      tests_run++;
      if (pwm_out !== exp_pwm) begin tests_failed++; $display("FAIL p4_pwm j=%0d: got %b want %b", j, pwm_out, exp_pwm); end
      tests_run++;
      if (prd_tick !== exp_tick) begin tests_failed++; $display("FAIL p4_tick j=%0d: got %b want %b", j, prd_tick, exp_tick); end
    end
  endtask

  task automatic test_readback();
    logic [31:0] d;
    logic [31:0] c;
    logic        v;
    write_reg(8'd3, 32'h1234);
    read_reg(8'd3, d, v);
    tests_run++;
    if (d !== 32'h1234 || v !== 1'b1) begin tests_failed++; $display("FAIL rb_duty: got %h/%b want 00001234/1", d, v); end
    tick();
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h1234) begin
      tests_failed++; $display("FAIL rb_hold: got valid=%b data=%h want 0/00001234", rd_valid, rd_data);
    end
    read_reg(8'hFF, d, v);
    tests_run++;
    if (d !== 32'h0 || v !== 1'b1) begin tests_failed++; $display("FAIL rb_unmapped: got %h/%b want 0/1", d, v); end
    read_reg(8'd0, d, v);
    tests_run++;
    if (d !== 32'h23) begin tests_failed++; $display("FAIL rb_ctrl: got %h want 00000023", d); end
    read_reg(8'd2, c, v);
    write_reg(8'd2, 32'hDEAD);
    read_reg(8'd2, d, v);
    tests_run++;
    if (d !== (c + 32'd2) % 32'd4) begin tests_failed++; $display("FAIL rb_cnt_ro: got %0d want %0d", d, (c + 32'd2) % 32'd4); end
    write_reg(8'd1, 32'd6);
    read_reg(8'd1, d, v);
    tests_run++;
    if (d !== 32'd6) begin tests_failed++; $display("FAIL rb_period_sh: got %0d want 6", d); end
  endtask

  task automatic test_disable_mid();
    bit          ok;
    logic [31:0] d;
    logic        v;
    write_reg(8'd1, 32'd10);
    write_reg(8'd3, 32'd3);
    ticks(20);
    wait_cnt(32'd4, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL dis_sync: got timeout want cnt=4"); end
    write_reg(8'd0, 32'h20);
    tick();
    tests_run++;
    if (pwm_out !== 4'b0001) begin tests_failed++; $display("FAIL dis_pwm: got %b want 0001", pwm_out); end
    read_reg(8'd2, d, v);
    tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL dis_cnt: got %0d want 0", d); end
    for (int j = 0; j < 12; j++) begin
      tick();
      tests_run++;
      if (prd_tick !== 1'b0 || pwm_out !== 4'b0001) begin
        tests_failed++; $display("FAIL dis_idle j=%0d: got tick=%b pwm=%b want 0/0001", j, prd_tick, pwm_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        v;
    write_reg(8'd0, 32'h3);
    ticks(5);
    read_reg(8'd0, d, v);
    tests_run++;
    if (d !== 32'h3) begin tests_failed++; $display("FAIL rstm_pre: got %h want 00000003", d); end
    rst = 1'b1; wr_en = 1'b1; wr_addr = 8'd1; wr_data = 32'h55; rd_en = 1'b1; rd_addr = 8'd0;
    tick();
    tests_run++;
    if (pwm_out !== 4'b0000 || prd_tick !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstm_out: got pwm=%b tick=%b valid=%b data=%h want 0/0/0/0", pwm_out, prd_tick, rd_valid, rd_data);
    end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      read_reg(ADDR_W'(a), d, v);
      tests_run++;
      if (d !== 32'h0) begin tests_failed++; $display("FAIL rstm_reg%0d: got %h want 0", a, d); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    test_reset();
    test_basic();
    test_duty_update();
    test_duty_terminal();
    test_duty_bounds();
    test_period_zero();
    test_readback();
    test_disable_mid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
